// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encodings, opcodes and the pipeline-control priority helper for the
// stall controller. Optional perf counters are enabled with STALL_PERF_CNT_EN.
package pipeline_stall_controller_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Opcodes shared with the hazard detection unit.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExFlush;
  } pipe_ctrl_t;

  // A memory stall freezes everything; a load-use bubble outranks a taken branch,
  // which is simply re-seen once the bubble has gone through.
  function automatic pipe_ctrl_t resolvePriority(input logic memStall,
                                                 input logic lwStall,
                                                 input logic branchTaken);
    pipe_ctrl_t c;
    c = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifIdFlush: 1'b0, idExFlush: 1'b0};
    if (memStall) begin
      c.pcWrite   = 1'b0;
      c.ifIdWrite = 1'b0;
    end else if (lwStall) begin
      c.pcWrite   = 1'b0;
      c.ifIdWrite = 1'b0;
      c.idExFlush = 1'b1;
    end else if (branchTaken) begin
      c.ifIdFlush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Data-memory handshake bundle between the MEM-stage controller and data memory.
interface pipeline_stall_controller_if;

  logic MEM_MemRead;
  logic MEM_MemWrite;
  logic mem_ack;
  logic mem_enable;
  logic mem_write;
  logic mem_err;

  modport master (
    input  MEM_MemRead,
    input  MEM_MemWrite,
    input  mem_ack,
    output mem_enable,
    output mem_write,
    output mem_err
  );

  modport slave (
    output MEM_MemRead,
    output MEM_MemWrite,
    output mem_ack,
    input  mem_enable,
    input  mem_write,
    input  mem_err
  );

endinterface

// File: rtl/pipeline_stall_controller_mem_access_fsm.sv
// MEM-stage request/acknowledge FSM: one access per instruction, abandoned after
// MEM_TIMEOUT wait cycles with a single error pulse.
module mem_access_fsm
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_memRead,
  input  logic i_memWrite,
  input  logic i_memAck,
  output logic o_memEnable,
  output logic o_memWrite,
  output logic o_memErr,
  output logic o_memStall
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_req;
  logic             w_active;
  logic             w_timeout;

  assign w_req = i_memRead | i_memWrite;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_active    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_active    = 1'b1;
          w_nextCnt   = '0;
          w_nextState = i_memAck ? DONE : WAIT;
        end
      end
      WAIT: begin
        w_active  = 1'b1;
        w_nextCnt = r_cnt + 1'b1;
        if (i_memAck) begin
          w_nextState = DONE;
        end else if (r_cnt == LAST_CNT) begin
          w_nextState = DONE;
          w_timeout   = 1'b1;
        end
      end
      // DONE lets the pipe advance once so the same instruction is never re-issued.
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  assign o_memEnable = w_active & ~i_rst;
  assign o_memStall  = o_memEnable;
  assign o_memWrite  = o_memEnable & i_memWrite;
  assign o_memErr    = w_timeout & ~i_rst;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer merging load-use stalls, branch flushes and the
// data-memory handshake. Define STALL_PERF_CNT_EN to add stall/flush counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic LwStall_i,
  input  logic Branch_taken_i,
  pipeline_stall_controller_if.master memBus,
  output logic PCWrite_o,
  output logic IF_ID_Write_o,
  output logic IF_ID_Flush_o,
  output logic ID_EX_Flush_o,
  output logic Stall_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cnt_o
`endif
);

  logic       w_memEnable;
  logic       w_memWrite;
  logic       w_memErr;
  logic       w_memStall;
  pipe_ctrl_t w_ctrl;

  mem_access_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_memFsm (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_memRead  (memBus.MEM_MemRead),
    .i_memWrite (memBus.MEM_MemWrite),
    .i_memAck   (memBus.mem_ack),
    .o_memEnable(w_memEnable),
    .o_memWrite (w_memWrite),
    .o_memErr   (w_memErr),
    .o_memStall (w_memStall)
  );

  always_comb begin
    w_ctrl = '0;
    if (!rst_i) begin
      w_ctrl = resolvePriority(w_memStall, LwStall_i, Branch_taken_i);
    end
  end

  assign PCWrite_o     = w_ctrl.pcWrite;
  assign IF_ID_Write_o = w_ctrl.ifIdWrite;
  assign IF_ID_Flush_o = w_ctrl.ifIdFlush;
  assign ID_EX_Flush_o = w_ctrl.idExFlush;
  assign Stall_o       = w_memStall;

  assign memBus.mem_enable = w_memEnable;
  assign memBus.mem_write  = w_memWrite;
  assign memBus.mem_err    = w_memErr;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushCnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stallCycles <= '0;
      r_flushCnt    <= '0;
    end else begin
      if (!PCWrite_o)   r_stallCycles <= r_stallCycles + 32'd1;
      if (IF_ID_Flush_o) r_flushCnt   <= r_flushCnt + 32'd1;
    end
  end

  assign stall_cycles_o = r_stallCycles;
  assign flush_cnt_o    = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller with a short timeout.
module tb_pipeline_stall_controller;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Stall, mem_enable, mem_write, mem_err}
  localparam logic [7:0] RST_V = 8'b0000_0000;
  localparam logic [7:0] RUN_V = 8'b1100_0000;
  localparam logic [7:0] LW_V  = 8'b0001_0000;
  localparam logic [7:0] BR_V  = 8'b1110_0000;
  localparam logic [7:0] RD_V  = 8'b0000_1100;
  localparam logic [7:0] WR_V  = 8'b0000_1110;
  localparam logic [7:0] ERR_V = 8'b0000_1101;

  logic clk;
  logic rst;
  logic lwStall;
  logic branchTaken;
  logic pcWrite;
  logic ifIdWrite;
  logic ifIdFlush;
  logic idExFlush;
  logic stall;
  int   testCount;
  int   failCount;

  pipeline_stall_controller_if memBus ();

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stallCycles;
  logic [31:0] flushCnt;
`endif

  pipeline_stall_controller #(
    .MEM_TIMEOUT(4),
    .CNT_W      (3)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .LwStall_i     (lwStall),
    .Branch_taken_i(branchTaken),
    .memBus        (memBus.master),
    .PCWrite_o     (pcWrite),
    .IF_ID_Write_o (ifIdWrite),
    .IF_ID_Flush_o (ifIdFlush),
    .ID_EX_Flush_o (idExFlush),
    .Stall_o       (stall)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles_o(stallCycles),
    .flush_cnt_o   (flushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One call per clock cycle: inputs change at the falling edge, outputs settle before the rising edge.
  task automatic applyStimulus(input logic r, input logic lw, input logic br,
                               input logic rd, input logic wr, input logic ack);
    @(negedge clk);
    rst                 = r;
    lwStall             = lw;
    branchTaken         = br;
    memBus.MEM_MemRead  = rd;
    memBus.MEM_MemWrite = wr;
    memBus.mem_ack      = ack;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {pcWrite, ifIdWrite, ifIdFlush, idExFlush, stall,
                memBus.mem_enable, memBus.mem_write, memBus.mem_err};
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b1; lwStall = 1'b0; branchTaken = 1'b0;
    memBus.MEM_MemRead = 1'b0; memBus.MEM_MemWrite = 1'b0; memBus.mem_ack = 1'b0;

    // Reset forces every output low even with requests present.
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("reset_quiet", RST_V);
    applyStimulus(1, 1, 1, 1, 1, 1); checkOutput("reset_busy", RST_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("idle_run", RUN_V);

    // Ack without a request is ignored: the next load still stalls from IDLE.
    applyStimulus(0, 0, 0, 0, 0, 1); checkOutput("stray_ack", RUN_V);
    applyStimulus(0, 0, 0, 1, 0, 1); checkOutput("ld_fast_idle", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("ld_fast_done", RUN_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("ld_fast_after", RUN_V);

    // Load acked on the third WAIT cycle.
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("ld_idle", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("ld_wait1", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("ld_wait2", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 1); checkOutput("ld_wait3_ack", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("ld_done", RUN_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("ld_after", RUN_V);

    // Store acked in IDLE, then read+write together behaves as a write.
    applyStimulus(0, 0, 0, 0, 1, 1); checkOutput("st_idle_ack", WR_V);
    applyStimulus(0, 0, 0, 0, 1, 0); checkOutput("st_done", RUN_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("st_after", RUN_V);
    applyStimulus(0, 0, 0, 1, 1, 1); checkOutput("rdwr_idle", WR_V);
    applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("rdwr_done", RUN_V);

    // No ack: error pulse in the fourth WAIT cycle, then release.
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("to_idle", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("to_wait1", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("to_wait2", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("to_wait3", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("to_wait4_err", ERR_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("to_done", RUN_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("to_after", RUN_V);

    // Load-use bubble beats a branch; the branch wins the following cycle.
    applyStimulus(0, 1, 1, 0, 0, 0); checkOutput("lw_and_br", LW_V);
    applyStimulus(0, 0, 1, 0, 0, 0); checkOutput("br_only", BR_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("br_after", RUN_V);

    // Load-use held during a memory stall only acts in DONE.
    applyStimulus(0, 1, 0, 1, 0, 0); checkOutput("lwmem_idle", RD_V);
    applyStimulus(0, 1, 0, 1, 0, 0); checkOutput("lwmem_wait1", RD_V);
    applyStimulus(0, 1, 0, 1, 0, 1); checkOutput("lwmem_wait2_ack", RD_V);
    applyStimulus(0, 1, 0, 1, 0, 0); checkOutput("lwmem_done", LW_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("lwmem_after", RUN_V);

    // Branch held during a store stall flushes in DONE.
    applyStimulus(0, 0, 1, 0, 1, 1); checkOutput("brmem_idle", WR_V);
    applyStimulus(0, 0, 1, 0, 1, 0); checkOutput("brmem_done", BR_V);

    // Reset in the second WAIT cycle aborts silently and returns to IDLE.
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("rstw_idle", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("rstw_wait1", RD_V);
    applyStimulus(1, 0, 0, 1, 0, 0); checkOutput("rstw_wait2_rst", RST_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("rstw_idle_after", RUN_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("rstw_quiet", RUN_V);

    // A fresh load after the abort must run the full timeout from zero.
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("rt_idle", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("rt_wait1", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("rt_wait2", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("rt_wait3", RD_V);
    applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("rt_wait4_err", ERR_V);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("rt_done", RUN_V);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges three sources into one set of pipeline-register controls:
  - the load-use stall request from the hazard detection unit,
  - the ID-stage branch-taken flush,
  - a multi-cycle data-memory handshake in MEM.
- Owns the MEM-stage memory request/acknowledge FSM.
- Sits between the hazard unit and branch compare logic on one side, and PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers and data memory on the other.

Parameters:
- MEM_TIMEOUT, 64, max WAIT cycles before access is abandoned (>=2)
- CNT_W, 7, width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- LwStall_i  in  1  load-use hazard request from hazard detection unit
- Branch_taken_i  in  1  branch resolved taken in ID this cycle
- MEM_MemRead_i  in  1  instruction in MEM performs a load
- MEM_MemWrite_i  in  1  instruction in MEM performs a store
- mem_ack_i  in  1  data memory access complete (data valid / write committed)
- PCWrite_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID register write enable
- IF_ID_Flush_o  out  1  clear IF/ID to NOP
- ID_EX_Flush_o  out  1  insert bubble into ID/EX
- Stall_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_enable_o  out  1  data memory request
- mem_write_o  out  1  request is a write
- mem_err_o  out  1  one-cycle pulse on access timeout

Behaviour:
- FSM states: IDLE, WAIT, DONE. Wait counter cnt is CNT_W bits.
- Reset (rst_i=1 at edge): state <= IDLE, cnt <= 0.
  - While rst_i=1, outputs are forced combinationally: PCWrite_o=0, IF_ID_Write_o=0, all flushes 0, Stall_o=0, mem_enable_o=0, mem_write_o=0, mem_err_o=0.
  - Reset mid-WAIT aborts the access with no error pulse.
- req = MEM_MemRead_i | MEM_MemWrite_i. If both are high, treat as a write.
- IDLE:
  - If req: mem_enable_o=1, Stall_o=1, cnt <= 0.
  - Next state: DONE if mem_ack_i, else WAIT.
  - If no req: mem_enable_o=0, Stall_o=0, and mem_ack_i is ignored.
- WAIT:
  - mem_enable_o=1 and Stall_o=1, including the ack cycle.
  - cnt increments each cycle.
  - On mem_ack_i: next state DONE.
  - If no ack and cnt==MEM_TIMEOUT-1: next state DONE, mem_err_o=1 this cycle.
- DONE:
  - mem_enable_o=0, Stall_o=0; pipeline advances one cycle; next state IDLE.
  - This guarantees one access per instruction and no re-issue.
- Minimum MEM residency is 2 cycles (IDLE then DONE).
- mem_write_o = mem_enable_o & MEM_MemWrite_i.
- Control priority, Moore on state plus Mealy on inputs:
  - Memory stall (Stall_o=1): PCWrite_o=0, IF_ID_Write_o=0, IF_ID_Flush_o=0, ID_EX_Flush_o=0. Whole pipe is frozen, so LwStall_i and Branch_taken_i are ignored; they stay asserted and are re-evaluated on release.
  - Else LwStall_i: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1, IF_ID_Flush_o=0. A simultaneous branch is ignored this cycle and re-evaluated after the bubble.
  - Else Branch_taken_i: PCWrite_o=1, IF_ID_Write_o=1, IF_ID_Flush_o=1.
  - Else all enables 1, flushes 0.
- In DONE, LwStall_i and Branch_taken_i follow the non-memory priority rules above.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles_o[31:0], counting cycles with PCWrite_o=0 and rst_i=0.
  - Adds flush_cnt_o[31:0], counting cycles with IF_ID_Flush_o=1.
  - Both wrap at 2**32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared include pipeline_ctrl_defs.vh holds:
  - state encodings IDLE=2'd0, WAIT=2'd1, DONE=2'd2,
  - opcode constants shared with the hazard detection unit.
- One natural sub-module, mem_access_fsm:
  - contains the state register, counter, mem_enable_o/mem_write_o/mem_err_o, and a mem_stall output;
  - the top combines mem_stall with the priority logic.

Test Plan:
- Load in MEM, ack on 3rd WAIT cycle -> Stall_o=1 for 4 cycles (IDLE + 3 WAIT), DONE for 1 cycle, mem_enable_o falls in DONE; exactly one request window.
- Store with ack in the IDLE cycle -> Stall_o=1 for 1 cycle, mem_write_o=1 that cycle, DONE next, IDLE after.
- No ack with MEM_TIMEOUT=4 -> mem_err_o pulses once in the 4th WAIT cycle, DONE follows, pipe released.
- LwStall_i=1 and Branch_taken_i=1 together with no memory op -> PCWrite_o=0, ID_EX_Flush_o=1, IF_ID_Flush_o=0; next cycle, with branch only -> IF_ID_Flush_o=1.
- LwStall_i=1 during WAIT -> ID_EX_Flush_o=0 until DONE, then ID_EX_Flush_o=1 in DONE.
- rst_i=1 in the 2nd WAIT cycle -> all outputs 0 that cycle; state is IDLE next cycle with mem_err_o never asserted.
